// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer
//   Frame-synchronous test-pattern scheduler. Sits between hvsync_generator
//   and the video encoder. It picks one of four test patterns and renders the
//   selected pattern's pixel colour. The pattern advances automatically every
//   FRAMES_PER_PATTERN frames. A host can also request a pattern through a
//   valid/ready port. A pattern change is applied only at a frame boundary
//   (rising edge of vsync_in), so a frame is never torn.
//
//   Build option:
//     VGA_SEQ_GRAY_RAMP_EN  defined     : pattern 2 is a gray ramp, g = counter_x[9:2]
//                           not defined : pattern 2 is solid 808080
//
// Ports:
//   clk, resetn             pixel clock, async active-low reset
//   counter_x, counter_y    beam position (11 bits each)
//   hsync_in, vsync_in      raw syncs, active-high
//   de_in                   display-area flag
//   auto_en                 level, 1 = automatic pattern cycling
//   cmd_valid, cmd_pattern  pattern request
//   cmd_ready               request can be accepted
//   pixel                   registered {R,G,B}
//   hsync_out, vsync_out    syncs delayed 1 cycle
//   pVDE                    de_in delayed 1 cycle
//   cur_pattern             pattern index currently rendered
//
// State    | meaning
// ---------+-------------------------------------------------------------
// S_AUTO   | cycling; advance every FRAMES_PER_PATTERN frame boundaries
// S_HOLD   | auto_en low; pattern and frame count frozen
// S_PEND   | host request latched; waiting for a frame boundary to apply it

module vga_pattern_sequencer #(
  parameter int H_ACTIVE           = 1280,
  parameter int V_ACTIVE           = 720,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [10:0] counter_x,
  input  logic [10:0] counter_y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  input  logic        auto_en,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_pattern,
  output logic        cmd_ready,
  output logic [23:0] pixel,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        pVDE,
  output logic [1:0]  cur_pattern
);

  localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [7:0]  FC_LAST = 8'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [1:0] {
    S_AUTO = 2'd0,
    S_HOLD = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t      state;
  logic        vsync_d;
  logic [7:0]  frame_cnt;
  logic [1:0]  pend_pat;
  logic        fb;
  logic        accept;
  logic [23:0] pix_next;

  assign fb        = vsync_in & ~vsync_d;
  // cmd_ready depends only on state. Reset forces S_AUTO, so it reads 1
  // during reset. Requests are still ignored while reset is held.
  assign cmd_ready = (state != S_PEND);
  assign accept    = cmd_valid & cmd_ready;
  // vsync_d is the registered copy of vsync_in, so it is the delayed sync.
  assign vsync_out = vsync_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_AUTO;
      frame_cnt   <= 8'd0;
      pend_pat    <= 2'd0;
      cur_pattern <= 2'd0;
    end else begin
      case (state)
        S_AUTO: begin
          // An accept beats both the auto-advance and an auto_en drop.
          if (accept) begin
            pend_pat <= cmd_pattern;
            state    <= S_PEND;
          end else begin
            if (fb) begin
              if (frame_cnt == FC_LAST) begin
                frame_cnt   <= 8'd0;
                cur_pattern <= cur_pattern + 2'd1;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
            if (!auto_en)
              state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (accept) begin
            pend_pat <= cmd_pattern;
            state    <= S_PEND;
          end else if (auto_en) begin
            frame_cnt <= 8'd0;
            state     <= S_AUTO;
          end
        end
        S_PEND: begin
          if (fb) begin
            cur_pattern <= pend_pat;
            frame_cnt   <= 8'd0;
            state       <= auto_en ? S_AUTO : S_HOLD;
          end
        end
        default: state <= S_AUTO;
      endcase
    end
  end

  always_comb begin
    pix_next = 24'h000000;
    if (de_in) begin
      case (cur_pattern)
        2'd0: begin
          if (counter_x < 11'd427)      pix_next = 24'h0000ff;
          else if (counter_x < 11'd853) pix_next = 24'h00ff00;
          else                          pix_next = 24'hff0000;
        end
        2'd1: pix_next = (counter_x[6] ^ counter_y[6]) ? 24'hffffff : 24'h000000;
        2'd2: begin
`ifdef VGA_SEQ_GRAY_RAMP_EN
          pix_next = {3{counter_x[9:2]}};
`else
          pix_next = 24'h808080;
`endif
        end
        default: begin
          if (counter_x == 11'd0 || counter_x == X_LAST ||
              counter_y == 11'd0 || counter_y == Y_LAST)
            pix_next = 24'hffffff;
        end
      endcase
    end
  end

  // Single register stage on pixel and syncs keeps them mutually aligned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel     <= 24'h000000;
      hsync_out <= 1'b0;
      vsync_d   <= 1'b0;
      pVDE      <= 1'b0;
    end else begin
      pixel     <= pix_next;
      hsync_out <= hsync_in;
      vsync_d   <= vsync_in;
      pVDE      <= de_in;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
module tb_vga_pattern_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [10:0] counter_x;
  logic [10:0] counter_y;
  logic        hsync_in;
  logic        vsync_in;
  logic        de_in;
  logic        auto_en;
  logic        cmd_valid;
  logic [1:0]  cmd_pattern;
  logic        cmd_ready;
  logic [23:0] pixel;
  logic        hsync_out;
  logic        vsync_out;
  logic        pVDE;
  logic [1:0]  cur_pattern;

  int checks = 0;
  int errors = 0;

  vga_pattern_sequencer #(
    .H_ACTIVE(1280), .V_ACTIVE(720), .FRAMES_PER_PATTERN(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .counter_x(counter_x), .counter_y(counter_y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .auto_en(auto_en), .cmd_valid(cmd_valid), .cmd_pattern(cmd_pattern),
    .cmd_ready(cmd_ready), .pixel(pixel),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .pVDE(pVDE),
    .cur_pattern(cur_pattern)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame boundary; the checks that follow see the state right after the fb edge.
  task automatic vsync_hi();
    vsync_in = 1'b1;
    tick();
  endtask

  task automatic vsync_lo();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [10:0] xs [6];
    logic [23:0] ex [6];
    xs = '{11'd0, 11'd426, 11'd427, 11'd500, 11'd852, 11'd900};
    ex = '{24'h0000ff, 24'h0000ff, 24'h00ff00, 24'h00ff00, 24'h00ff00, 24'hff0000};
    resetn = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b1;
    counter_x = 11'd5; counter_y = 11'd10; auto_en = 1'b1;
    cmd_valid = 1'b1; cmd_pattern = 2'd2;
    repeat (3) tick();
    checks++; if (pixel !== 24'h0) begin errors++; $display("FAIL reset_pixel got %h want 000000", pixel); end
    checks++; if ({hsync_out, vsync_out, pVDE} !== 3'b000) begin errors++; $display("FAIL reset_syncs got %b want 000", {hsync_out, vsync_out, pVDE}); end
    checks++; if (cur_pattern !== 2'd0) begin errors++; $display("FAIL reset_cur got %0d want 0", cur_pattern); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    hsync_in = 1'b0; vsync_in = 1'b0; cmd_valid = 1'b0;
    resetn = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ignored ready got %b want 1", cmd_ready); end
    for (int i = 0; i < 6; i++) begin
      counter_x = xs[i];
      tick();
      checks++;
      if (pixel !== ex[i]) begin errors++; $display("FAIL bars_x%0d got %h want %h", xs[i], pixel, ex[i]); end
    end
  endtask

  task automatic test_auto_cycle();
    logic [1:0] seq [9];
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    checks++; if (cur_pattern !== seq[0]) begin errors++; $display("FAIL auto_f0 got %0d want %0d", cur_pattern, seq[0]); end
    for (int k = 1; k < 9; k++) begin
      vsync_hi();
      checks++;
      if (cur_pattern !== seq[k]) begin errors++; $display("FAIL auto_f%0d got %0d want %0d", k, cur_pattern, seq[k]); end
      vsync_lo();
      tick();
    end
  endtask

  task automatic test_command();
    cmd_valid = 1'b1; cmd_pattern = 2'd3;
    tick();
    cmd_valid = 1'b0; cmd_pattern = 2'd0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_low got %b want 0", cmd_ready); end
    repeat (4) tick();
    checks++; if (cmd_ready !== 1'b0 || cur_pattern !== 2'd0) begin errors++; $display("FAIL cmd_wait ready %b cur %0d want 0 0", cmd_ready, cur_pattern); end
    vsync_hi();
    checks++; if (cur_pattern !== 2'd3) begin errors++; $display("FAIL cmd_apply got %0d want 3", cur_pattern); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_back got %b want 1", cmd_ready); end
    vsync_lo();
    counter_x = 11'd0; counter_y = 11'd5; tick();
    checks++; if (pixel !== 24'hffffff) begin errors++; $display("FAIL border_0_5 got %h want ffffff", pixel); end
    counter_x = 11'd5; tick();
    checks++; if (pixel !== 24'h000000) begin errors++; $display("FAIL border_5_5 got %h want 000000", pixel); end
    counter_x = 11'd1279; counter_y = 11'd300; tick();
    checks++; if (pixel !== 24'hffffff) begin errors++; $display("FAIL border_xlast got %h want ffffff", pixel); end
    counter_x = 11'd1278; tick();
    checks++; if (pixel !== 24'h000000) begin errors++; $display("FAIL border_x1278 got %h want 000000", pixel); end
    counter_x = 11'd640; counter_y = 11'd719; tick();
    checks++; if (pixel !== 24'hffffff) begin errors++; $display("FAIL border_ylast got %h want ffffff", pixel); end
    // frame_cnt restarted: one more fb keeps 3, the next wraps to 0
    vsync_hi();
    checks++; if (cur_pattern !== 2'd3) begin errors++; $display("FAIL cmd_cnt_restart got %0d want 3", cur_pattern); end
    vsync_lo();
    vsync_hi();
    checks++; if (cur_pattern !== 2'd0) begin errors++; $display("FAIL cmd_wrap got %0d want 0", cur_pattern); end
    vsync_lo();
  endtask

  task automatic test_collision();
    vsync_hi(); vsync_lo();            // frame_cnt = 1, cur 0: next fb would advance
    vsync_in = 1'b1; cmd_valid = 1'b1; cmd_pattern = 2'd1;
    tick();
    cmd_valid = 1'b0; cmd_pattern = 2'd0;
    checks++; if (cur_pattern !== 2'd0) begin errors++; $display("FAIL collide_stay got %0d want 0", cur_pattern); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL collide_ready got %b want 0", cmd_ready); end
    vsync_lo();
    tick();
    vsync_hi();
    checks++; if (cur_pattern !== 2'd1) begin errors++; $display("FAIL collide_apply got %0d want 1", cur_pattern); end
    vsync_lo();
  endtask

  task automatic test_hold();
    vsync_hi(); vsync_lo();            // frame_cnt = 1, cur 1
    auto_en = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      vsync_hi();
      checks++;
      if (cur_pattern !== 2'd1) begin errors++; $display("FAIL hold_f%0d got %0d want 1", k, cur_pattern); end
      vsync_lo();
    end
    auto_en = 1'b1;
    tick();
    vsync_hi();
    checks++; if (cur_pattern !== 2'd1) begin errors++; $display("FAIL hold_cnt_cleared got %0d want 1", cur_pattern); end
    vsync_lo();
    vsync_hi();
    checks++; if (cur_pattern !== 2'd2) begin errors++; $display("FAIL hold_resume got %0d want 2", cur_pattern); end
    vsync_lo();
  endtask

  task automatic test_checker_ramp();
    logic [23:0] gray_exp;
`ifdef VGA_SEQ_GRAY_RAMP_EN
    gray_exp = 24'h646464;
`else
    gray_exp = 24'h808080;
`endif
    auto_en = 1'b0;
    cmd_valid = 1'b1; cmd_pattern = 2'd1; tick();
    cmd_valid = 1'b0;
    vsync_hi(); vsync_lo();
    checks++; if (cur_pattern !== 2'd1) begin errors++; $display("FAIL pat1_apply got %0d want 1", cur_pattern); end
    counter_x = 11'd64; counter_y = 11'd0; tick();
    checks++; if (pixel !== 24'hffffff) begin errors++; $display("FAIL checker_64_0 got %h want ffffff", pixel); end
    counter_y = 11'd64; tick();
    checks++; if (pixel !== 24'h000000) begin errors++; $display("FAIL checker_64_64 got %h want 000000", pixel); end
    counter_x = 11'd0; tick();
    checks++; if (pixel !== 24'hffffff) begin errors++; $display("FAIL checker_0_64 got %h want ffffff", pixel); end
    cmd_valid = 1'b1; cmd_pattern = 2'd2; tick();
    cmd_valid = 1'b0;
    vsync_hi(); vsync_lo();
    checks++; if (cur_pattern !== 2'd2) begin errors++; $display("FAIL pat2_apply got %0d want 2", cur_pattern); end
    counter_x = 11'd400; counter_y = 11'd7; tick();
    checks++; if (pixel !== gray_exp) begin errors++; $display("FAIL gray_400 got %h want %h", pixel, gray_exp); end
    de_in = 1'b0; tick();
    checks++; if (pixel !== 24'h000000) begin errors++; $display("FAIL blank_pixel got %h want 000000", pixel); end
    // Sync/DE pipeline: old value before the edge, new value after it.
    for (int i = 1; i < 8; i++) begin
      logic [2:0] prev, cur;
      prev = {hsync_in, vsync_in, de_in};
      cur  = 3'(i);
      {hsync_in, vsync_in, de_in} = cur;
      #1;
      checks++;
      if ({hsync_out, vsync_out, pVDE} !== prev) begin errors++; $display("FAIL sync_pre%0d got %b want %b", i, {hsync_out, vsync_out, pVDE}, prev); end
      tick();
      checks++;
      if ({hsync_out, vsync_out, pVDE} !== cur) begin errors++; $display("FAIL sync_post%0d got %b want %b", i, {hsync_out, vsync_out, pVDE}, cur); end
    end
    checks++; if (pixel !== gray_exp) begin errors++; $display("FAIL pixel_align got %h want %h", pixel, gray_exp); end
    hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b1;
    tick();
  endtask

  task automatic test_reset_pend();
    auto_en = 1'b1;
    cmd_valid = 1'b1; cmd_pattern = 2'd3; tick();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rpend_ready got %b want 0", cmd_ready); end
    resetn = 1'b0; tick();
    resetn = 1'b1; tick();
    checks++; if (cmd_ready !== 1'b1 || cur_pattern !== 2'd0) begin errors++; $display("FAIL rpend_after ready %b cur %0d want 1 0", cmd_ready, cur_pattern); end
    vsync_hi();
    checks++; if (cur_pattern !== 2'd0) begin errors++; $display("FAIL rpend_discard got %0d want 0", cur_pattern); end
    vsync_lo();
  endtask

  initial begin
    test_reset();
    test_auto_cycle();
    test_command();
    test_collision();
    test_hold();
    test_checker_ramp();
    test_reset_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sequencer.md
# vga_pattern_sequencer

Frame-synchronous test-pattern scheduler for the VGA/HDMI pattern generator. Takes raw beam position and sync from `hvsync_generator`, chooses one of four test patterns, and renders the selected pattern's pixel colour. Advances automatically every `FRAMES_PER_PATTERN` frames, or switches to a host-requested pattern through a valid/ready command port. Pattern changes only take effect at a frame boundary, so a frame is never torn. Sits between `hvsync_generator` and the video encoder, and replaces the fixed colour-bar logic.

## Interface
Parameters:
- `H_ACTIVE`, default 1280: active pixels per line.
- `V_ACTIVE`, default 720: active lines per frame.
- `FRAMES_PER_PATTERN`, default 60: frames shown per pattern in auto mode; range 1..255.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `counter_x`  in  11  beam column from `hvsync_generator`.
- `counter_y`  in  11  beam row from `hvsync_generator`.
- `hsync_in`, `vsync_in`  in  1  raw syncs, active-high.
- `de_in`  in  1  display-area flag.
- `auto_en`  in  1  level; 1 = automatic pattern cycling.
- `cmd_valid`  in  1  pattern request valid.
- `cmd_pattern`  in  2  requested pattern index.
- `cmd_ready`  out  1  request can be accepted.
- `pixel`  out  24  RGB, `{R,G,B}`, registered.
- `hsync_out`, `vsync_out`  out  1  syncs delayed 1 cycle.
- `pVDE`  out  1  `de_in` delayed 1 cycle.
- `cur_pattern`  out  2  pattern index currently rendered.

## Operation
- **Frame boundary:** `fb = vsync_in & ~vsync_d`, where `vsync_d` is `vsync_in` registered.
- **Patterns**, evaluated only when `de_in` = 1; otherwise `pixel` = 0:
  - 0, colour bars: `x < 427` gives `0000ff`; `x < 853` gives `00ff00`; else `ff0000`.
  - 1, checkerboard: `counter_x[6] ^ counter_y[6]` gives `ffffff`, else `000000`.
  - 2, gray ramp: `g = counter_x[9:2]`, pixel `{g,g,g}`, wraps at x = 1024. See Configuration.
  - 3, border: `ffffff` when x = 0, x = `H_ACTIVE`-1, y = 0 or y = `V_ACTIVE`-1; `000000` elsewhere.
- **FSM states:** `S_AUTO`, `S_HOLD`, `S_PEND`. Also holds `frame_cnt` (8 bits) and `pend_pat` (2 bits).
- **`cmd_ready`:** 1 in `S_AUTO` and `S_HOLD`; 0 in `S_PEND`. It is combinational from state only.
- **Accept:** `cmd_valid & cmd_ready` latches `pend_pat <= cmd_pattern` and moves to `S_PEND`.
- **`S_AUTO`:**
  - On `fb` with no accept: if `frame_cnt == FRAMES_PER_PATTERN-1`, `frame_cnt <= 0` and `cur_pattern <= cur_pattern+1` (wraps 3 to 0); else `frame_cnt++`.
  - `auto_en` = 0 with no accept moves to `S_HOLD`, keeping `frame_cnt`.
- **`S_HOLD`:** `cur_pattern` and `frame_cnt` are frozen. `auto_en` = 1 moves to `S_AUTO` and clears `frame_cnt`.
- **`S_PEND`:** on `fb`, `cur_pattern <= pend_pat` and `frame_cnt <= 0`. Next state is `S_AUTO` if `auto_en`, else `S_HOLD`.
- **Simultaneous events:**
  - Accept and `fb` in the same cycle: the accept wins. The auto-advance is suppressed, and the new pattern is applied at the *next* `fb`.
  - Accept and `auto_en` change in the same cycle: the accept wins; `auto_en` is re-evaluated on leaving `S_PEND`.
- **Reset:** reset asserted mid-frame or mid-`S_PEND` discards the pending command.

## Timing
- **Reset values:**
  - Outputs: `pixel` = 0, `hsync_out` = 0, `vsync_out` = 0, `pVDE` = 0, `cur_pattern` = 0.
  - Internal: state `S_AUTO`, `frame_cnt` = 0, `vsync_d` = 0.
  - `cmd_ready` reads 1 during reset; requests are ignored while `resetn` = 0.
- **Pipeline:** `pixel`, `hsync_out`, `vsync_out` and `pVDE` each have exactly 1 cycle latency from their inputs, so they stay mutually aligned.
- **Pattern switch:** `cur_pattern` updates on the clock edge where `fb` = 1. That edge is inside vertical blanking, so the first active pixel of the new frame uses the new pattern.
- **Handshake:** a command is accepted on the rising edge where `cmd_valid` and `cmd_ready` are both 1. `cmd_ready` falls 1 cycle later and rises again in the cycle after the `fb` that applies it. `cmd_pattern` is only sampled at the accept edge.

## Configuration
- **`VGA_SEQ_GRAY_RAMP_EN` defined:** pattern 2 is the gray ramp described above.
- **Not defined:** pattern 2 is solid mid-gray `808080` inside the display area, and the ramp logic is absent.
- The FSM, handshake and pattern numbering are identical in both builds.

## Test plan
- **Reset mid-line:**
  - Stimulus: hold `resetn` = 0 for 3 cycles.
  - Response: all outputs 0 and `cmd_ready` = 1. After release, the first active pixel at x = 0 is `0000ff`, x = 500 is `00ff00`, x = 900 is `ff0000`.
- **Auto cycling:**
  - Stimulus: `FRAMES_PER_PATTERN` = 2, `auto_en` = 1, run 9 frames.
  - Response: `cur_pattern` sequence by frame is 0,0,1,1,2,2,3,3,0. Each change lands on the `fb` edge.
- **Command:**
  - Stimulus: in frame 0, pulse `cmd_valid` with `cmd_pattern` = 3.
  - Response: `cmd_ready` = 0 until the next `fb`. `cur_pattern` = 3 from that edge. Pixel (0,5) = `ffffff` and (5,5) = `000000`. `frame_cnt` restarts at 0.
- **Collision:**
  - Stimulus: accept `cmd_pattern` = 1 on the exact `fb` cycle when auto would advance 0 to 1.
  - Response: `cur_pattern` stays 0 for that frame and becomes 1 at the following `fb`.
- **Hold:**
  - Stimulus: drop `auto_en` for 5 frames, then raise it.
  - Response: `cur_pattern` is frozen while low. After `auto_en` rises, the next advance comes `FRAMES_PER_PATTERN` frames later.
- **Checker/ramp and sync alignment:**
  - Stimulus: pattern 1, then pattern 2, driving x and y.
  - Response:
    - Pattern 1: pixel(64,0) = `ffffff`, pixel(64,64) = `000000`.
    - Pattern 2: pixel(400,y) = `646464`, or `808080` with the macro undefined.
    - `pVDE`, `hsync_out` and `vsync_out` each trail their input by exactly 1 cycle.
